// File: rtl/bw_io_impctl_pkg.sv
// Shared constants and state encoding for the impedance-control shadow-scan master.
package bw_io_impctl_pkg;

  localparam int IMPCTL_SZ_W       = 8;
  localparam int IMPCTL_CHAIN_BITS = 9;

  typedef enum logic [2:0] {
    IDLE,
    CAPT,
    SHIFT,
    UPD,
    DONE
  } sscan_state_e;

  function automatic int chain_len(input int num_ctl);
    return num_ctl * IMPCTL_CHAIN_BITS;
  endfunction

endpackage

// File: rtl/bw_io_impctl_sscan_sreg.sv
// Serial-in read-back shift register; new bits enter at the MSB, so the bit
// sampled in shift cycle k ends up at index k after a full pass.
module bw_io_impctl_sscan_sreg
  import bw_io_impctl_pkg::*;
#(
  parameter int LEN = IMPCTL_CHAIN_BITS
) (
  input  logic           clk,
  input  logic           shift_en,
  input  logic           din,
  output logic [LEN-1:0] q,
  output logic [LEN-1:0] q_next
);

  assign q_next = shift_en ? {din, q[LEN-1:1]} : q;

  // NOTE: pure datapath storage is left unreset; it is always fully
  // overwritten before anything downstream consumes it.
  always_ff @(posedge clk) begin
    q <= q_next;
  end

endmodule

// File: rtl/bw_io_impctl_sscan_mstr.sv
// Shadow-scan master: capture, full-chain shift with freeze injection,
// optional update pulse, then publish the read-back codes for one cycle.
module bw_io_impctl_sscan_mstr
  import bw_io_impctl_pkg::*;
#(
  parameter int NUM_CTL = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           update_en,
  input  logic [NUM_CTL-1:0]             freeze_req,
  output logic                           sscan_se,
  output logic                           sscan_out,
  output logic                           sscan_update,
  input  logic                           sscan_in,
  output logic                           busy,
  output logic                           done,
  output logic [IMPCTL_SZ_W*NUM_CTL-1:0] sz_code,
  output logic [NUM_CTL-1:0]             freeze_shadow
);

  localparam int L  = chain_len(NUM_CTL);
  localparam int CW = $clog2(L);

  sscan_state_e     state, state_nxt;
  logic [CW-1:0]    k, k_nxt;
  logic             upd_lat, upd_lat_nxt;
  logic [NUM_CTL-1:0] frz_lat, frz_lat_nxt;

  logic se_nxt, out_nxt, update_nxt, busy_nxt, done_nxt;
  logic [L-1:0] drive_vec;

  logic [L-1:0] rb_q, rb_next, rb;
  logic [IMPCTL_SZ_W*NUM_CTL-1:0] sz_nxt;
  logic [NUM_CTL-1:0]             fs_nxt;

  bw_io_impctl_sscan_sreg #(.LEN(L)) u_sreg (
    .clk      (clk),
    .shift_en (state == SHIFT),
    .din      (sscan_in),
    .q        (rb_q),
    .q_next   (rb_next)
  );

  // NOTE: every always_comb output gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    k_nxt       = k;
    upd_lat_nxt = upd_lat;
    frz_lat_nxt = frz_lat;
    unique case (state)
      IDLE: if (start) begin
        upd_lat_nxt = update_en;
        frz_lat_nxt = freeze_req;
        state_nxt   = CAPT;
      end
      CAPT: begin
        k_nxt     = '0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        if (k == CW'(L - 1)) state_nxt = upd_lat ? UPD : DONE;
        else                 k_nxt     = k + 1'b1;
      end
      UPD:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Freeze bit for controller i must be driven in the cycle that leaves it in
  // the first flop of controller i once the pass completes.
  always_comb begin
    drive_vec = '0;
    for (int i = 0; i < NUM_CTL; i++)
      drive_vec[IMPCTL_CHAIN_BITS*(NUM_CTL-1-i) + 8] = frz_lat_nxt[i];
  end

  // Outputs are decoded from the next state so they can be registered. se
  // stays high through DONE so the chain only recaptures once back in IDLE.
  always_comb begin
    se_nxt     = state_nxt inside {SHIFT, UPD, DONE};
    out_nxt    = (state_nxt == SHIFT) ? drive_vec[k_nxt] : 1'b0;
    update_nxt = state_nxt == UPD;
    busy_nxt   = state_nxt inside {CAPT, SHIFT, UPD};
    done_nxt   = (state_nxt == DONE) && (state != DONE);
  end

  // The last chain bit is sampled on the same edge that enters DONE, so take
  // the pre-shifted view unless the pass already finished before UPD.
  always_comb begin
    rb     = (state == UPD) ? rb_q : rb_next;
    sz_nxt = '0;
    fs_nxt = '0;
    for (int i = 0; i < NUM_CTL; i++) begin
      for (int j = 0; j < IMPCTL_SZ_W; j++)
        sz_nxt[IMPCTL_SZ_W*i + j] = rb[IMPCTL_CHAIN_BITS*(NUM_CTL-1-i) + j];
      fs_nxt[i] = rb[IMPCTL_CHAIN_BITS*(NUM_CTL-1-i) + 8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      k             <= '0;
      upd_lat       <= 1'b0;
      frz_lat       <= '0;
      sscan_se      <= 1'b0;
      sscan_out     <= 1'b0;
      sscan_update  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      sz_code       <= '0;
      freeze_shadow <= '0;
    end else begin
      state        <= state_nxt;
      k            <= k_nxt;
      upd_lat      <= upd_lat_nxt;
      frz_lat      <= frz_lat_nxt;
      sscan_se     <= se_nxt;
      sscan_out    <= out_nxt;
      sscan_update <= update_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      if (done_nxt) begin
        sz_code       <= sz_nxt;
        freeze_shadow <= fs_nxt;
      end
    end
  end

endmodule

// File: tb/tb_bw_io_impctl_sscan_mstr.sv
// Bench for the shadow-scan master: three chain widths, each against a
// behavioural 9-bit-per-controller shadow chain with freeze loaded on update.
module tb_bw_io_impctl_sscan_mstr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start[3];
  logic       update_en[3];
  logic [7:0] freeze_req[3];
  logic       se[3], sout[3], upd[3], sin[3], busy[3], done[3];

  logic [7:0]  sz0;
  logic [15:0] sz1;
  logic [63:0] sz2;
  logic        fs0;
  logic [1:0]  fs1;
  logic [7:0]  fs2;

  int vectors     = 0;
  int miscompares = 0;

  int nctl[3] = '{1, 2, 8};
  int len[3]  = '{9, 18, 72};

  // Behavioural chain: position 0 is next to the master's serial output;
  // controller i owns positions 9i (freeze) .. 9i+8 (code bit 0).
  logic [71:0] chain[3];
  logic [7:0]  code[3][8];
  logic [7:0]  frz[3]     = '{default: '0};
  int          upd_cnt[3] = '{0, 0, 0};

  bw_io_impctl_sscan_mstr #(.NUM_CTL(1)) dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .update_en(update_en[0]),
    .freeze_req(freeze_req[0][0:0]), .sscan_se(se[0]), .sscan_out(sout[0]),
    .sscan_update(upd[0]), .sscan_in(sin[0]), .busy(busy[0]), .done(done[0]),
    .sz_code(sz0), .freeze_shadow(fs0));

  bw_io_impctl_sscan_mstr #(.NUM_CTL(2)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .update_en(update_en[1]),
    .freeze_req(freeze_req[1][1:0]), .sscan_se(se[1]), .sscan_out(sout[1]),
    .sscan_update(upd[1]), .sscan_in(sin[1]), .busy(busy[1]), .done(done[1]),
    .sz_code(sz1), .freeze_shadow(fs1));

  bw_io_impctl_sscan_mstr #(.NUM_CTL(8)) dut2 (
    .clk(clk), .reset(reset), .start(start[2]), .update_en(update_en[2]),
    .freeze_req(freeze_req[2]), .sscan_se(se[2]), .sscan_out(sout[2]),
    .sscan_update(upd[2]), .sscan_in(sin[2]), .busy(busy[2]), .done(done[2]),
    .sz_code(sz2), .freeze_shadow(fs2));

  assign sin[0] = chain[0][8];
  assign sin[1] = chain[1][17];
  assign sin[2] = chain[2][71];

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (upd[d] === 1'b1) begin
        upd_cnt[d] = upd_cnt[d] + 1;
        for (int i = 0; i < nctl[d]; i++) frz[d][i] <= chain[d][9*i];
      end else if (se[d] === 1'b1) begin
        chain[d] <= {chain[d][70:0], sout[d]};
      end else begin
        for (int i = 0; i < nctl[d]; i++) begin
          chain[d][9*i] <= frz[d][i];
          for (int j = 0; j < 8; j++) chain[d][9*i+8-j] <= code[d][i][j];
        end
      end
    end
  end

  function automatic logic [63:0] get_sz(input int d);
    case (d)
      0:       return {56'b0, sz0};
      1:       return {48'b0, sz1};
      default: return sz2;
    endcase
  endfunction

  function automatic logic [7:0] get_fs(input int d);
    case (d)
      0:       return {7'b0, fs0};
      1:       return {6'b0, fs1};
      default: return fs2;
    endcase
  endfunction

  function automatic logic [63:0] exp_sz(input int d);
    logic [63:0] v = '0;
    for (int i = 0; i < nctl[d]; i++) v[8*i +: 8] = code[d][i];
    return v;
  endfunction

  function automatic logic [7:0] ctl_mask(input int d);
    return 8'((9'd1 << nctl[d]) - 9'd1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // One transaction on DUT d. If poke_cyc>0, a competing start with poke_fr
  // is driven in that cycle after acceptance and must be ignored.
  task automatic run_txn(input int d, input bit ue, input logic [7:0] fr,
                         input int poke_cyc, input logic [7:0] poke_fr, input string tag);
    int          cyc, u0;
    bit          got;
    logic [63:0] esz;
    logic [7:0]  efs, efrz;
    esz  = exp_sz(d);
    efs  = frz[d] & ctl_mask(d);
    efrz = ue ? (fr & ctl_mask(d)) : frz[d];
    u0   = upd_cnt[d];
    @(negedge clk);
    start[d] = 1'b1; update_en[d] = ue; freeze_req[d] = fr;
    @(negedge clk);
    start[d] = 1'b0; update_en[d] = 1'($urandom); freeze_req[d] = 8'($urandom);
    cyc = 1; got = 0;
    chk({tag, " busy_after_start"}, 64'(busy[d]), 64'd1);
    while (cyc <= 200) begin
      if (done[d] === 1'b1) begin got = 1; break; end
      if (cyc == poke_cyc) begin
        start[d] = 1'b1; freeze_req[d] = poke_fr; update_en[d] = !ue;
      end else start[d] = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start[d] = 1'b0;
    chk({tag, " done_seen"}, 64'(got), 64'd1);
    chk({tag, " latency"}, 64'(cyc), 64'(len[d] + 2 + int'(ue)));
    chk({tag, " sz_code"}, get_sz(d), esz);
    chk({tag, " freeze_shadow"}, 64'(get_fs(d)), 64'(efs));
    chk({tag, " busy_in_done"}, 64'(busy[d]), 64'd0);
    chk({tag, " update_pulses"}, 64'(upd_cnt[d] - u0), 64'(ue));
    chk({tag, " model_freeze"}, 64'(frz[d]), 64'(efrz));
    @(negedge clk);
    chk({tag, " done_single"}, 64'(done[d]), 64'd0);
    chk({tag, " sz_hold"}, get_sz(d), esz);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset se",     64'(se[d]),   64'd0);
      chk("reset out",    64'(sout[d]), 64'd0);
      chk("reset upd",    64'(upd[d]),  64'd0);
      chk("reset busy",   64'(busy[d]), 64'd0);
      chk("reset done",   64'(done[d]), 64'd0);
      chk("reset sz",     get_sz(d),    64'd0);
      chk("reset fs",     64'(get_fs(d)), 64'd0);
    end
  endtask

  task automatic test_single_n1();
    code[0][0] = 8'hA5;
    run_txn(0, 1'b0, 8'h01, 0, 8'h0, "n1");
  endtask

  task automatic test_update_n2();
    code[1][0] = 8'h3C; code[1][1] = 8'hC3;
    run_txn(1, 1'b1, 8'b10, 0, 8'h0, "n2upd");
    chk("n2upd sz_literal", get_sz(1), 64'hC33C);
    chk("n2upd frz_literal", 64'(frz[1]), 64'h2);
    // A second pass must read back the freeze loaded by the first update.
    run_txn(1, 1'b0, 8'b01, 0, 8'h0, "n2readback");
  endtask

  task automatic test_back_to_back();
    int cyc, gap, se_low;
    bit got;
    code[1][0] = 8'h5A; code[1][1] = 8'h96;
    @(negedge clk);
    start[1] = 1'b1; update_en[1] = 1'b0; freeze_req[1] = 8'h0;
    cyc = 0; got = 0;
    while (cyc < 100) begin
      @(negedge clk); cyc++;
      if (done[1] === 1'b1) begin got = 1; break; end
    end
    chk("b2b first_done", 64'(cyc), 64'(len[1] + 2));
    gap = 0; se_low = 0; got = 0;
    while (gap < 100) begin
      @(negedge clk); gap++;
      if (se[1] === 1'b0) se_low++;
      if (done[1] === 1'b1) begin got = 1; break; end
    end
    start[1] = 1'b0;
    chk("b2b second_done", 64'(got), 64'd1);
    chk("b2b period", 64'(gap), 64'(len[1] + 3));
    chk("b2b se_low_cycles", 64'(se_low), 64'd2);
    chk("b2b sz_code", get_sz(1), exp_sz(1));
    repeat (3) @(negedge clk);
    chk("b2b idle_after", 64'(busy[1]), 64'd0);
  endtask

  task automatic test_reset_abort();
    int u0;
    logic [7:0] f0;
    code[1][0] = 8'h81; code[1][1] = 8'h7E;
    run_txn(1, 1'b0, 8'h0, 0, 8'h0, "pre_abort");
    u0 = upd_cnt[1]; f0 = frz[1];
    @(negedge clk);
    start[1] = 1'b1; update_en[1] = 1'b1; freeze_req[1] = ~f0;
    @(negedge clk);
    start[1] = 1'b0;
    repeat (6) @(negedge clk);     // now in SHIFT cycle k=5
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort se",   64'(se[1]),   64'd0);
    chk("abort busy", 64'(busy[1]), 64'd0);
    chk("abort done", 64'(done[1]), 64'd0);
    chk("abort sz",   get_sz(1),    64'd0);
    chk("abort fs",   64'(get_fs(1)), 64'd0);
    repeat (25) @(negedge clk);
    chk("abort no_update", 64'(upd_cnt[1] - u0), 64'd0);
    chk("abort frz_kept",  64'(frz[1]), 64'(f0));
    chk("abort stays_idle", 64'(busy[1]), 64'd0);
  endtask

  task automatic test_start_while_busy();
    logic [7:0] fr;
    fr = 8'($urandom_range(0, 3));
    code[1][0] = 8'($urandom); code[1][1] = 8'($urandom);
    run_txn(1, 1'b1, fr, 10, ~fr, "busy_start");
    chk("busy_start idle_after", 64'(busy[1]), 64'd0);
  endtask

  task automatic test_wide_n8();
    for (int i = 0; i < 8; i++) code[2][i] = 8'h00;
    run_txn(2, 1'b0, 8'h0, 0, 8'h0, "n8_zero");
    for (int i = 0; i < 8; i++) code[2][i] = 8'hFF;
    run_txn(2, 1'b0, 8'h0, 0, 8'h0, "n8_ones");
    for (int i = 0; i < 8; i++) code[2][i] = 8'($urandom);
    run_txn(2, 1'b1, 8'($urandom), 0, 8'h0, "n8_rand_upd");
    run_txn(2, 1'b0, 8'h0, 0, 8'h0, "n8_readback");
  endtask

  task automatic test_random();
    int d;
    for (int t = 0; t < 12; t++) begin
      d = int'($urandom_range(0, 2));
      for (int i = 0; i < nctl[d]; i++) code[d][i] = 8'($urandom);
      run_txn(d, 1'($urandom), 8'($urandom), 0, 8'h0, "rand");
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start[d] = 1'b0; update_en[d] = 1'b0; freeze_req[d] = '0;
      for (int i = 0; i < 8; i++) code[d][i] = '0;
    end
    test_reset();
    test_single_n1();
    test_update_n2();
    test_back_to_back();
    test_reset_abort();
    test_start_while_busy();
    test_wide_n8();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
